sr_latch_driver: RTL and testbench
==================================

// Module: sr_latch_driver
// PURPOSE
//   Sequencer that drives an SR latch with clean, glitch-free, never-overlapping
//   set/reset pulses, then reads the latch outputs back to confirm the new state.
//   It accepts one set/clear request at a time on a valid/ready handshake and
//   reports done, plus err on a readback mismatch. It sits between a
//   synchronous controller and any level-sensitive SR storage element.
// PARAMETERS
//   PULSE_W         2  cycles s or r is held high per operation (>=1)
//   CHK_W           1  settle cycles with s=r=0 before readback sample (>=1)
//   GAP_W           1  cycles after done before req_ready returns (>=0)
//   SKIP_REDUNDANT  1  1: skip the pulse when the request matches the known latch state
// PORTS
//   clk          in   1  rising-edge clock
//   rst          in   1  reset, asynchronous, active-high
//   req_valid    in   1  request present
//   req_ready    out  1  driver can accept; transfer when valid&&ready at clk edge
//   req_set      in   1  1 = set (q->1), 0 = reset (q->0); sampled at transfer
//   s            out  1  set drive to latch, registered
//   r            out  1  reset drive to latch, registered
//   q_fb         in   1  latch q readback
//   q_bar_fb     in   1  latch q_bar readback
//   done         out  1  one-cycle completion pulse
//   err          out  1  one-cycle pulse, only with done: readback mismatch
//   state_q      out  1  last confirmed latch value
//   state_known  out  1  state_q is valid (a check has passed since reset)
// BEHAVIOUR
//   One clock. Reset is asynchronous and active-high.
//   Reset: IDLE, s=r=0, req_ready=1, done=err=0, state_q=0, state_known=0.
//     Reset asserted mid-operation forces s=r=0 at once. The operation is dropped, and no done is issued.
//   FSM states: IDLE -> PULSE -> SETTLE -> GAP -> IDLE. Counter width is $clog2 of the largest parameter + 1.
//   IDLE: req_ready=1. On transfer, latch dir=req_set.
//     If SKIP_REDUNDANT && state_known && dir==state_q: done=1 next cycle, err=0, no pulse, then GAP.
//     Otherwise go to PULSE.
//   PULSE: s=dir, r=~dir for exactly PULSE_W cycles. The first of these is the cycle after the transfer.
//   SETTLE: s=r=0 for CHK_W cycles. The edge ending the last SETTLE cycle samples q_fb and q_bar_fb.
//     The sample passes iff q_fb==dir && q_bar_fb==~dir.
//     q_fb==q_bar_fb, or any X/Z (compare with ===), is a fail.
//   done is high for the one cycle after the sample edge.
//     On pass: err=0, state_q<=dir, state_known<=1.
//     On fail: err=1, state_known<=0, state_q is unchanged.
//   GAP: begins in the done cycle and lasts GAP_W cycles with req_ready=0.
//     With GAP_W=0 the done cycle is in IDLE with req_ready=1, so a request may transfer in the done cycle.
//   req_ready=0 in PULSE, SETTLE and GAP. While busy, req_valid is ignored: no queue, no error.
//   Latency for a driven request: transfer to done is PULSE_W+CHK_W+1 cycles.
//     Transfer to the next req_ready is that plus GAP_W.
//   Invariant: s&&r is never 1. Between opposite operations there are always >=CHK_W cycles with s=r=0.
//   s, r, done and err come straight from flops, with no combinational path from inputs.
// TESTING
//   Set request, defaults, after reset:
//     transfer at cycle 0 -> s=1 in cycles 1-2, r=0, settle in cycle 3, done=1 and err=0 in cycle 4,
//     state_q=1 and state_known=1, req_ready=1 again in cycle 5.
//   Reset request after a successful set: r=1 for 2 cycles, s=0 throughout -> done, err=0, state_q=0.
//   Faulty latch model with q_fb stuck at 0, set request -> done and err both 1, state_known=0.
//     A repeated set then pulses again instead of skipping.
//   Redundant set after a successful set (SKIP_REDUNDANT=1) -> s/r stay 0, done the cycle after transfer, err=0.
//   rst asserted in cycle 1 of PULSE -> s=0 immediately, no done, req_ready=1 after release, state_known=0.
//   Random request stream with a behavioural sr_latch model, GAP_W=0 -> s&&r never 1, every transfer yields exactly one done,
//     back-to-back transfers are accepted in the done cycle.

Source files
------------

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: sequences non-overlapping set/reset pulses into a
// level-sensitive SR latch, then samples the latch readback to confirm the
// new state. Requests are accepted one at a time on a valid/ready handshake.
module sr_latch_driver #(
  parameter int PULSE_W        = 2,     // cycles s or r is held high (>=1)
  parameter int CHK_W          = 1,     // settle cycles before readback (>=1)
  parameter int GAP_W          = 1,     // cycles after done before ready (>=0)
  parameter bit SKIP_REDUNDANT = 1'b1   // skip pulse when latch already holds dir
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_set,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic q_bar_fb,
  output logic done,
  output logic err,
  output logic state_q,
  output logic state_known
);

  localparam int MAX_PW = (PULSE_W > CHK_W) ? ((PULSE_W > GAP_W) ? PULSE_W : GAP_W)
                                            : ((CHK_W > GAP_W) ? CHK_W : GAP_W);
  localparam int CNT_W  = $clog2(MAX_PW) + 1;

  // Counters hold "cycles remaining minus one" so the last cycle is cnt == 0.
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] CHK_LD   = CNT_W'(CHK_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_W > 0) ? (GAP_W - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_GAP
  } fsm_e;

  // With no gap the done cycle is already an IDLE cycle.
  localparam fsm_e AFTER_DONE = (GAP_W > 0) ? ST_GAP : ST_IDLE;

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             state_d;
  logic             known_q, known_d;

  logic xfer;
  logic skip;
  logic last;
  logic sample_pass;

  assign req_ready   = (fsm_q == ST_IDLE);
  assign xfer        = req_valid && req_ready;
  assign skip        = SKIP_REDUNDANT && known_q && (req_set == state_q);
  assign last        = (cnt_q == '0);
  // Case equality so that a floating or unknown readback counts as a failure.
  assign sample_pass = (q_fb === dir_q) && (q_bar_fb === ~dir_q);

  assign s           = s_q;
  assign r           = r_q;
  assign done        = done_q;
  assign err         = err_q;
  assign state_known = known_q;

  // State register: FSM, counter, latched direction and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      state_q <= 1'b0;
      known_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
      state_q <= state_d;
      known_q <= known_d;
    end
  end

  // Next-state logic: walk IDLE -> PULSE -> SETTLE -> GAP, timing each phase.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (xfer) begin
          dir_d = req_set;
          if (skip) begin
            fsm_d = AFTER_DONE;
            cnt_d = GAP_LD;
          end else begin
            fsm_d = ST_PULSE;
            cnt_d = PULSE_LD;
          end
        end
      end
      ST_PULSE: begin
        if (last) begin
          fsm_d = ST_SETTLE;
          cnt_d = CHK_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (last) begin
          fsm_d = AFTER_DONE;
          cnt_d = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (last) begin
          fsm_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: registered drive, completion pulse and confirmed latch state.
  always_comb begin
    s_d     = 1'b0;
    r_d     = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    state_d = state_q;
    known_d = known_q;
    // s and r are complementary copies of dir only while pulsing, so they can
    // never both be high and every phase change passes through s=r=0.
    if (fsm_d == ST_PULSE) begin
      s_d = dir_d;
      r_d = ~dir_d;
    end
    if ((fsm_q == ST_IDLE) && xfer && skip) begin
      done_d = 1'b1;
    end
    if ((fsm_q == ST_SETTLE) && last) begin
      done_d = 1'b1;
      if (sample_pass) begin
        state_d = dir_q;
        known_d = 1'b1;
      end else begin
        err_d   = 1'b1;
        known_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Testbench for sr_latch_driver: a cycle table and directed sequences on a
// default-parameter instance, then a random request stream on a GAP_W=0
// instance checked against a transaction-level timing model.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic vld_a = 1'b0, set_a = 1'b0, rdy_a, s_a, r_a, qfb_a, qbfb_a;
  logic done_a, err_a, st_a, kn_a;
  logic lq_a;
  logic stuck_a = 1'b0;

  // Instance B: no gap after done.
  logic vld_b = 1'b0, set_b = 1'b0, rdy_b, s_b, r_b, qfb_b, qbfb_b;
  logic done_b, err_b, st_b, kn_b;
  logic lq_b;

  sr_latch_driver dut_a (
    .clk(clk), .rst(rst), .req_valid(vld_a), .req_ready(rdy_a), .req_set(set_a),
    .s(s_a), .r(r_a), .q_fb(qfb_a), .q_bar_fb(qbfb_a), .done(done_a), .err(err_a),
    .state_q(st_a), .state_known(kn_a)
  );

  sr_latch_driver #(.PULSE_W(2), .CHK_W(1), .GAP_W(0), .SKIP_REDUNDANT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vld_b), .req_ready(rdy_b), .req_set(set_b),
    .s(s_b), .r(r_b), .q_fb(qfb_b), .q_bar_fb(qbfb_b), .done(done_b), .err(err_b),
    .state_q(st_b), .state_known(kn_b)
  );

  // Behavioural level-sensitive SR latches; A can have q readback stuck at 0.
  always @(s_a or r_a) begin
    if (s_a && !r_a)      lq_a = 1'b1;
    else if (r_a && !s_a) lq_a = 1'b0;
  end
  assign qfb_a  = stuck_a ? 1'b0 : lq_a;
  assign qbfb_a = ~lq_a;

  always @(s_b or r_b) begin
    if (s_b && !r_b)      lq_b = 1'b1;
    else if (r_b && !s_b) lq_b = 1'b0;
  end
  assign qfb_b  = lq_b;
  assign qbfb_b = ~lq_b;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One row per clock cycle: inputs driven in that cycle, outputs expected in it.
  typedef struct packed {
    logic vld;
    logic set;
    logic s;
    logic r;
    logic done;
    logic err;
    logic rdy;
    logic st;
    logic kn;
  } vec_t;

  vec_t vec [13];

  task automatic wait_ready_a(input string name);
    int k = 0;
    while (!rdy_a && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_ready_timeout"}, {31'd0, rdy_a}, 32'd1);
  endtask

  // Issue one request on A and follow it to done; lat is transfer-to-done
  // in cycles, or -1 if done never came within the bound.
  task automatic do_req_a(input logic set, output int lat, output logic saw_s,
                          output logic saw_r, output logic err_o);
    lat   = -1;
    saw_s = 1'b0;
    saw_r = 1'b0;
    err_o = 1'b0;
    wait_ready_a("req");
    vld_a = 1'b1;
    set_a = set;
    @(posedge clk); #1;
    vld_a = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      saw_s |= s_a;
      saw_r |= r_a;
      if (done_a) begin
        lat   = c;
        err_o = err_a;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic ss, sr, se;
    logic saw_done;
    int   ready_at, done_at, xfer_at;
    logic pending, skip_p, m_dir, m_state, m_known;
    logic exp_done, exp_ready, exp_s, exp_r, v, st;
    int   n_xfer, n_done, n_b2b;

    //                 vld set  s r  done err  rdy  st kn
    vec[0]  = 9'b1_1_0_0_0_0_1_0_0;  // set request transfers
    vec[1]  = 9'b0_0_1_0_0_0_0_0_0;  // pulse 1
    vec[2]  = 9'b1_0_1_0_0_0_0_0_0;  // pulse 2, request ignored while busy
    vec[3]  = 9'b0_0_0_0_0_0_0_0_0;  // settle
    vec[4]  = 9'b0_0_0_0_1_0_0_1_1;  // done, gap
    vec[5]  = 9'b1_0_0_0_0_0_1_1_1;  // reset request transfers
    vec[6]  = 9'b0_0_0_1_0_0_0_1_1;
    vec[7]  = 9'b1_1_0_1_0_0_0_1_1;  // ignored while busy
    vec[8]  = 9'b0_0_0_0_0_0_0_1_1;
    vec[9]  = 9'b0_0_0_0_1_0_0_0_1;
    vec[10] = 9'b1_0_0_0_0_0_1_0_1;  // redundant reset request
    vec[11] = 9'b0_0_0_0_1_0_0_0_1;  // skipped: done next cycle
    vec[12] = 9'b0_0_0_0_0_0_1_0_1;

    // Reset state while rst is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, rdy_a}, 32'd1);
    check("rst_s",     {31'd0, s_a},   32'd0);
    check("rst_r",     {31'd0, r_a},   32'd0);
    check("rst_done",  {31'd0, done_a}, 32'd0);
    check("rst_err",   {31'd0, err_a}, 32'd0);
    check("rst_state", {31'd0, st_a},  32'd0);
    check("rst_known", {31'd0, kn_a},  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      vld_a = vec[i].vld;
      set_a = vec[i].set;
      check($sformatf("vec%0d_s", i),     {31'd0, s_a},    {31'd0, vec[i].s});
      check($sformatf("vec%0d_r", i),     {31'd0, r_a},    {31'd0, vec[i].r});
      check($sformatf("vec%0d_done", i),  {31'd0, done_a}, {31'd0, vec[i].done});
      check($sformatf("vec%0d_err", i),   {31'd0, err_a},  {31'd0, vec[i].err});
      check($sformatf("vec%0d_ready", i), {31'd0, rdy_a},  {31'd0, vec[i].rdy});
      check($sformatf("vec%0d_state", i), {31'd0, st_a},   {31'd0, vec[i].st});
      check($sformatf("vec%0d_known", i), {31'd0, kn_a},   {31'd0, vec[i].kn});
      @(posedge clk); #1;
    end
    vld_a = 1'b0;
    set_a = 1'b0;

    // Set, then a redundant set that must be skipped.
    do_req_a(1'b1, lat, ss, sr, se);
    check("set_lat",   lat, 32'd4);
    check("set_saw_s", {31'd0, ss}, 32'd1);
    check("set_saw_r", {31'd0, sr}, 32'd0);
    check("set_err",   {31'd0, se}, 32'd0);
    check("set_state", {31'd0, st_a}, 32'd1);
    do_req_a(1'b1, lat, ss, sr, se);
    check("redund_lat",   lat, 32'd1);
    check("redund_saw_s", {31'd0, ss}, 32'd0);
    check("redund_saw_r", {31'd0, sr}, 32'd0);
    check("redund_err",   {31'd0, se}, 32'd0);

    // Reset after a successful set.
    do_req_a(1'b0, lat, ss, sr, se);
    check("clr_lat",   lat, 32'd4);
    check("clr_saw_s", {31'd0, ss}, 32'd0);
    check("clr_saw_r", {31'd0, sr}, 32'd1);
    check("clr_err",   {31'd0, se}, 32'd0);
    check("clr_state", {31'd0, st_a}, 32'd0);

    // Faulty latch: readback q stuck at 0.
    stuck_a = 1'b1;
    do_req_a(1'b1, lat, ss, sr, se);
    check("fault_lat",   lat, 32'd4);
    check("fault_err",   {31'd0, se}, 32'd1);
    check("fault_known", {31'd0, kn_a}, 32'd0);
    check("fault_state", {31'd0, st_a}, 32'd0);
    do_req_a(1'b1, lat, ss, sr, se);
    check("fault2_lat",   lat, 32'd4);
    check("fault2_saw_s", {31'd0, ss}, 32'd1);
    check("fault2_err",   {31'd0, se}, 32'd1);
    stuck_a = 1'b0;
    do_req_a(1'b1, lat, ss, sr, se);
    check("recover_err",   {31'd0, se}, 32'd0);
    check("recover_state", {31'd0, st_a}, 32'd1);
    check("recover_known", {31'd0, kn_a}, 32'd1);
    do_req_a(1'b0, lat, ss, sr, se);
    check("recover_clr_err", {31'd0, se}, 32'd0);

    // Reset asserted in the first pulse cycle of a set.
    wait_ready_a("rstmid");
    vld_a = 1'b1;
    set_a = 1'b1;
    @(posedge clk); #1;
    vld_a = 1'b0;
    check("rstmid_pulse_s", {31'd0, s_a}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_s_now", {31'd0, s_a}, 32'd0);
    check("rstmid_r_now", {31'd0, r_a}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      saw_done |= done_a;
      @(posedge clk); #1;
    end
    check("rstmid_no_done", {31'd0, saw_done}, 32'd0);
    check("rstmid_ready",   {31'd0, rdy_a}, 32'd1);
    check("rstmid_known",   {31'd0, kn_a}, 32'd0);

    // Random stream on instance B against a transaction-level timing model:
    // a driven request finishes 4 cycles after transfer, a skipped one after 1,
    // and with no gap the driver is ready again in the done cycle.
    pending = 1'b0; skip_p = 1'b0; m_dir = 1'b0; m_state = 1'b0; m_known = 1'b0;
    ready_at = 0; done_at = -1; xfer_at = -10;
    n_xfer = 0; n_done = 0; n_b2b = 0;
    for (int c = 0; c < 410; c++) begin
      exp_done = pending && (c == done_at);
      if (exp_done) begin
        pending = 1'b0;
        if (!skip_p) begin
          m_state = m_dir;
          m_known = 1'b1;
        end
      end
      exp_ready = (c >= ready_at);
      exp_s = pending && !skip_p && (c > xfer_at) && (c <= xfer_at + 2) && m_dir;
      exp_r = pending && !skip_p && (c > xfer_at) && (c <= xfer_at + 2) && !m_dir;
      if (done_b) n_done++;
      check($sformatf("rnd%0d_ready", c), {31'd0, rdy_b}, {31'd0, exp_ready});
      check($sformatf("rnd%0d_done", c),  {31'd0, done_b}, {31'd0, exp_done});
      check($sformatf("rnd%0d_s", c),     {31'd0, s_b}, {31'd0, exp_s});
      check($sformatf("rnd%0d_r", c),     {31'd0, r_b}, {31'd0, exp_r});
      check($sformatf("rnd%0d_overlap", c), {31'd0, s_b && r_b}, 32'd0);
      if (exp_done) begin
        check($sformatf("rnd%0d_err", c),   {31'd0, err_b}, 32'd0);
        check($sformatf("rnd%0d_state", c), {31'd0, st_b}, {31'd0, m_state});
        check($sformatf("rnd%0d_known", c), {31'd0, kn_b}, {31'd0, m_known});
      end
      v  = (c < 400) && (exp_done || ($urandom_range(0, 1) == 1));
      st = ($urandom_range(0, 1) == 1);
      vld_b = v;
      set_b = st;
      if (v && exp_ready) begin
        n_xfer++;
        if (exp_done) n_b2b++;
        skip_p  = m_known && (st == m_state);
        m_dir   = st;
        pending = 1'b1;
        xfer_at = c;
        done_at = c + (skip_p ? 1 : 4);
        ready_at = done_at;
      end
      @(posedge clk); #1;
    end
    vld_b = 1'b0;
    check("rnd_done_count", n_done, n_xfer);
    check("rnd_some_xfers", {31'd0, n_xfer > 10}, 32'd1);
    check("rnd_b2b_seen",   {31'd0, n_b2b > 0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
